// File: rtl/music_box_sequencer_if.sv
// music_box_sequencer_if: control/data handshake between the sequencer and the song memory.
interface music_box_sequencer_if;
  logic [3:0] song;
  logic       stop;
  logic       start;
  logic       step;
  logic [1:0] duration;
  logic [4:0] notecase;
  modport master (output song, stop, start, step, input duration, notecase);
  modport slave (input song, stop, start, step, output duration, notecase);
endinterface

// File: rtl/music_box_sequencer.sv
// music_box_sequencer: turns song/stop button edges into memory load/step strobes and times notes and gaps.
module music_box_sequencer #(
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    song_req,
  input  logic                          stop_req,
  music_box_sequencer_if.master         mem,
  output logic                          sound_en,
  output logic                          playing,
  output logic [1:0]                    cur_song
);
  typedef enum logic [3:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, STEP, SETTLE, FETCH, NOTE, GAP} state_t;
  localparam logic [4:0] END_MARK = 5'b01000;
  state_t      state, state_n;
  logic [31:0] cnt, cnt_n, note_len;
  logic [3:0]  song_prev, song_edge, sel, sel_n;
  logic        stop_prev, stop_edge, stop_sel, stop_n, play_n;
  logic [1:0]  win, cur_n;
  logic        load;
  assign song_edge = song_req & ~song_prev;
  assign stop_edge = stop_req & ~stop_prev;
  assign win       = song_edge[0] ? 2'd0 : song_edge[1] ? 2'd1 : song_edge[2] ? 2'd2 : 2'd3;
  assign note_len  = (32'(mem.duration) + 32'd1) * 32'(TICK_DIV) - 32'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      stop_sel  <= 1'b0;
      playing   <= 1'b0;
      cur_song  <= '0;
      song_prev <= '0;
      stop_prev <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sel       <= sel_n;
      stop_sel  <= stop_n;
      playing   <= play_n;
      cur_song  <= cur_n;
      song_prev <= song_req;
      stop_prev <= stop_req;
    end
  end
  // Request edges are checked first so they override any terminal count in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    stop_n  = stop_sel;
    play_n  = playing;
    cur_n   = cur_song;
    if (stop_edge) begin
      state_n = LOAD_A;
      cnt_n   = '0;
      sel_n   = '0;
      stop_n  = 1'b1;
      play_n  = 1'b0;
    end else if (|song_edge) begin
      state_n = LOAD_A;
      cnt_n   = '0;
      sel_n   = 4'b0001 << win;
      stop_n  = 1'b0;
      play_n  = 1'b1;
      cur_n   = win;
    end else begin
      case (state)
        LOAD_A: state_n = LOAD_B;
        LOAD_B: state_n = LOAD_C;
        LOAD_C: state_n = stop_sel ? IDLE : STEP;
        STEP:   state_n = SETTLE;
        SETTLE: state_n = FETCH;
        FETCH: begin
          state_n = (mem.notecase == END_MARK) ? IDLE : NOTE;
          play_n  = (mem.notecase == END_MARK) ? 1'b0 : playing;
          cnt_n   = (mem.notecase == END_MARK) ? cnt : note_len;
        end
        NOTE: begin
          state_n = (cnt == '0) ? GAP : NOTE;
          cnt_n   = (cnt == '0) ? 32'(GAP_CYCLES) - 32'd1 : cnt - 32'd1;
        end
        GAP: begin
          state_n = (cnt == '0) ? STEP : GAP;
          cnt_n   = (cnt == '0) ? cnt : cnt - 32'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  assign load      = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
  assign mem.song  = load ? sel : 4'b0000;
  assign mem.stop  = load & stop_sel;
  assign mem.start = (state == LOAD_B);
  assign mem.step  = (state == STEP);
  assign sound_en  = (state == NOTE);
endmodule

// File: tb/tb_music_box_sequencer.sv
// tb_music_box_sequencer: directed playback scenarios against a small song-memory model and a width scoreboard.
module tb_music_box_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] song_req;
  logic       stop_req;
  logic       sound_en, playing;
  logic [1:0] cur_song;
  int         n_vec = 0;
  int         n_bad = 0;
  int         exp_q[$];
  int         prog[$];
  int         idx;
  music_box_sequencer_if mem_if();
  music_box_sequencer #(.TICK_DIV(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .song_req(song_req), .stop_req(stop_req),
    .mem(mem_if), .sound_en(sound_en), .playing(playing), .cur_song(cur_song)
  );
  always #5 clk = ~clk;
  // Memory model: start rewinds, each step presents the next entry of prog, then the end marker.
  always @(posedge clk) begin
    if (rst || mem_if.start) begin
      idx             <= 0;
      mem_if.notecase <= 5'b01000;
      mem_if.duration <= 2'b00;
    end else if (mem_if.step) begin
      mem_if.notecase <= (idx < prog.size()) ? 5'b00011 : 5'b01000;
      mem_if.duration <= (idx < prog.size()) ? 2'(prog[idx]) : 2'b00;
      idx             <= idx + 1;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pop_exp();
    return (exp_q.size() != 0) ? exp_q.pop_front() : -1;
  endfunction
  task automatic play_note(input string tag);
    int t, w, g;
    t = 0;
    w = 0;
    g = 0;
    while (!sound_en && t < 60) begin tick(); t++; end
    while (sound_en && w < 100) begin tick(); w++; end
    check({tag, "_width"}, 32'(w), 32'(pop_exp()));
    while (!mem_if.step && g < 60) begin tick(); g++; end
    check({tag, "_gap"}, 32'(g), 32'd2);
  endtask
  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (playing && t < 40) begin tick(); t++; end
    check({tag, "_idle"}, 32'({playing, sound_en}), 32'd0);
  endtask
  task automatic count_strobes(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick();
      if (mem_if.step || mem_if.start || sound_en) c++;
    end
  endtask
  initial begin
    int c;
    rst      = 1'b1;
    song_req = 4'b0000;
    stop_req = 1'b0;
    tick(3);
    check("reset_outs", 32'({mem_if.song, mem_if.stop, mem_if.start, mem_if.step, sound_en, playing, cur_song}), 32'd0);
    rst = 1'b0;
    tick(2);
    // single song, d=01 then end marker
    prog = '{1};
    song_req = 4'b0001;
    exp_q.push_back(8);
    tick();
    check("load_a", 32'({mem_if.song, mem_if.start, playing}), 32'({4'b0001, 1'b0, 1'b1}));
    song_req = 4'b0000;
    tick();
    check("start_hi", 32'(mem_if.start), 32'd1);
    tick();
    check("load_c", 32'({mem_if.song, mem_if.start}), 32'({4'b0001, 1'b0}));
    tick();
    check("step_hi", 32'({mem_if.step, mem_if.song}), 32'({1'b1, 4'b0000}));
    tick(2);
    check("fetch_quiet", 32'({mem_if.step, sound_en}), 32'd0);
    tick();
    check("note_on", 32'(sound_en), 32'd1);
    play_note("s1");
    tick(2);
    check("end_fetch_playing", 32'(playing), 32'd1);
    tick();
    check("end_idle", 32'({playing, sound_en}), 32'd0);
    count_strobes(10, c);
    check("s1_no_strobes", 32'(c), 32'd0);
    // simultaneous songs 2 and 3, held high
    prog = '{0};
    song_req = 4'b0110;
    exp_q.push_back(4);
    tick();
    check("arb_cur", 32'(cur_song), 32'd1);
    check("arb_sel", 32'(mem_if.song), 32'b0010);
    play_note("arb");
    wait_idle("arb");
    count_strobes(20, c);
    check("held_no_reload", 32'(c), 32'd0);
    song_req = 4'b0000;
    tick();
    // preempt a long note with song 3
    prog = '{3};
    song_req = 4'b0001;
    tick();
    song_req = 4'b0000;
    c = 0;
    while (!sound_en && c < 30) begin tick(); c++; end
    tick(3);
    song_req = 4'b0100;
    exp_q.push_back(16);
    tick();
    check("pre_sound_off", 32'(sound_en), 32'd0);
    check("pre_sel", 32'({mem_if.song, cur_song}), 32'({4'b0100, 2'd2}));
    song_req = 4'b0000;
    play_note("pre");
    wait_idle("pre");
    // stop and song 4 together: stop wins
    stop_req = 1'b1;
    song_req = 4'b1000;
    tick();
    check("stop_sel", 32'({mem_if.stop, mem_if.song, playing}), 32'({1'b1, 4'b0000, 1'b0}));
    stop_req = 1'b0;
    song_req = 4'b0000;
    tick(2);
    check("stop_load_c", 32'({mem_if.stop, mem_if.start}), 32'({1'b1, 1'b0}));
    tick();
    check("stop_cleared", 32'({mem_if.stop, mem_if.step, playing}), 32'd0);
    count_strobes(15, c);
    check("stop_no_step", 32'(c), 32'd0);
    // all four durations back to back
    prog = '{0, 1, 2, 3};
    song_req = 4'b0001;
    exp_q.push_back(4);
    exp_q.push_back(8);
    exp_q.push_back(12);
    exp_q.push_back(16);
    tick();
    song_req = 4'b0000;
    play_note("d00");
    play_note("d01");
    play_note("d10");
    play_note("d11");
    wait_idle("durs");
    // async reset during a gap
    prog = '{1};
    song_req = 4'b0100;
    exp_q.push_back(8);
    tick();
    song_req = 4'b0000;
    c = 0;
    while (!sound_en && c < 30) begin tick(); c++; end
    while (sound_en && c < 60) begin tick(); c++; end
    check("rst_pre_cur", 32'({playing, cur_song}), 32'({1'b1, 2'd2}));
    void'(pop_exp());
    #2 rst = 1'b1;
    #1;
    check("rst_async", 32'({mem_if.song, mem_if.stop, mem_if.start, mem_if.step, sound_en, playing, cur_song}), 32'd0);
    tick(2);
    rst = 1'b0;
    count_strobes(20, c);
    check("rst_quiet", 32'({c[7:0], playing}), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
